// File: rtl/conv5x5_controller.sv
// Sequencer for the 5x5 MAC/ReLU processor: weight/bias load, row-major window walk, one
// registered 64-bit result per output pixel on a valid/ready stream.
module conv5x5_controller #(
   parameter int IMG_W    = 28,
   parameter int IMG_H    = 28,
   parameter int ADDR_W   = 16,
   parameter int IMG_BASE = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              keep_w,
   output logic              busy,
   output logic              done,
   output logic              img_rd,
   output logic [ADDR_W-1:0] img_addr,
   input  logic [31:0]       img_data,
   output logic              w_rd,
   output logic [4:0]        w_addr,
   input  logic [31:0]       w_data,
   output logic [31:0]       mac_data,
   output logic [31:0]       mac_weight,
   output logic [4:0]        mac_data_count,
   output logic [4:0]        mac_weight_count,
   output logic              mac_data_en,
   output logic              mac_weight_en,
   output logic              mac_update,
   input  logic [63:0]       mac_answer,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [63:0]       out_data,
   output logic              out_last
);

   typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_WIN, SLIDE, SETTLE, OUT} state_t;

   state_t            state, state_nxt;
   logic [4:0]        cnt;
   logic [2:0]        r, c;
   logic [ADDR_W-1:0] orow, ocol;
   logic              wen_d, den_d, upd_d, done_q;
   logic [4:0]        idx_d;
   logic [63:0]       out_q;

   logic              rd_w, rd_img, rd_upd;
   logic [2:0]        rsel, csel;
   logic [4:0]        img_idx, rd_idx;
   logic [ADDR_W-1:0] row_sel, col_sel, addr_c;
   logic              last_px, row_end, hs;

   assign row_end = (ocol == ADDR_W'(IMG_W - 5));
   assign last_px = row_end && (orow == ADDR_W'(IMG_H - 5));
   assign hs      = (state == OUT) && out_ready;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Each load state issues its reads, then spends one extra cycle letting the last write land.
   always_comb begin
      state_nxt = state;
      rd_w      = 1'b0;
      rd_img    = 1'b0;
      rd_upd    = 1'b0;
      rsel      = 3'd0;
      csel      = 3'd0;
      case (state)
         IDLE: begin
            if (start) state_nxt = keep_w ? LOAD_WIN : LOAD_W;
         end
         LOAD_W: begin
            if (cnt == 5'd26) state_nxt = LOAD_WIN;
            else              rd_w = 1'b1;
         end
         LOAD_WIN: begin
            if (cnt == 5'd25) state_nxt = SETTLE;
            else begin
               rd_img = 1'b1;
               rsel   = r;
               csel   = c;
            end
         end
         SLIDE: begin
            if (cnt == 5'd5) state_nxt = SETTLE;
            else begin
               rd_img = 1'b1;
               rsel   = cnt[2:0];
               csel   = 3'd4;
               rd_upd = (cnt == 5'd0);
            end
         end
         SETTLE: state_nxt = OUT;
         OUT: begin
            if (out_ready) begin
               if (last_px)      state_nxt = IDLE;
               else if (row_end) state_nxt = LOAD_WIN;
               else              state_nxt = SLIDE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign img_idx = {rsel[2:0], 2'b00} + {2'b00, rsel} + {2'b00, csel};
   assign rd_idx  = rd_w ? cnt : img_idx;
   assign row_sel = orow + ADDR_W'(rsel);
   assign col_sel = ocol + ADDR_W'(csel);
   assign addr_c  = ADDR_W'(IMG_BASE) + row_sel * ADDR_W'(IMG_W) + col_sel;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         r      <= '0;
         c      <= '0;
         orow   <= '0;
         ocol   <= '0;
         wen_d  <= 1'b0;
         den_d  <= 1'b0;
         upd_d  <= 1'b0;
         idx_d  <= '0;
         done_q <= 1'b0;
         out_q  <= '0;
      end else begin
         wen_d  <= rd_w;
         den_d  <= rd_img;
         upd_d  <= rd_upd;
         idx_d  <= (rd_w || rd_img) ? rd_idx : 5'd0;
         done_q <= hs && last_px;

         if ((state_nxt == state) &&
             (state == LOAD_W || state == LOAD_WIN || state == SLIDE))
            cnt <= cnt + 5'd1;
         else
            cnt <= '0;

         if (state == LOAD_WIN && rd_img) begin
            if (c == 3'd4) begin
               c <= '0;
               r <= r + 3'd1;
            end else begin
               c <= c + 3'd1;
            end
         end else if (state != LOAD_WIN) begin
            r <= '0;
            c <= '0;
         end

         if (state == IDLE && start) begin
            orow <= '0;
            ocol <= '0;
         end else if (hs && !last_px) begin
            if (row_end) begin
               ocol <= '0;
               orow <= orow + ADDR_W'(1);
            end else begin
               ocol <= ocol + ADDR_W'(1);
            end
         end

         if (state == SETTLE) out_q <= mac_answer;
      end
   end

   assign busy             = (state != IDLE);
   assign done             = done_q;
   assign img_rd           = rd_img;
   assign img_addr         = rd_img ? addr_c : '0;
   assign w_rd             = rd_w;
   assign w_addr           = rd_w ? cnt : 5'd0;
   // Pass-through data is gated so the processor ports sit at zero between writes.
   assign mac_data         = den_d ? img_data : 32'd0;
   assign mac_weight       = wen_d ? w_data : 32'd0;
   assign mac_data_count   = den_d ? idx_d : 5'd0;
   assign mac_weight_count = wen_d ? idx_d : 5'd0;
   assign mac_data_en      = den_d;
   assign mac_weight_en    = wen_d;
   assign mac_update       = upd_d;
   assign out_valid        = (state == OUT);
   assign out_data         = out_q;
   assign out_last         = (state == OUT) && last_px;

endmodule

// File: tb/tb_conv5x5_controller.sv
// Bench for conv5x5_controller on a 6x6 image, with behavioural RAMs and 5x5 MAC/ReLU processor.
module tb_conv5x5_controller;
   localparam int W  = 6;
   localparam int H  = 6;
   localparam int AW = 16;

   logic          clk, reset, start, keep_w, busy, done;
   logic          img_rd, w_rd;
   logic [AW-1:0] img_addr;
   logic [31:0]   img_data, w_data, mac_data, mac_weight;
   logic [4:0]    w_addr, mac_data_count, mac_weight_count;
   logic          mac_data_en, mac_weight_en, mac_update;
   logic [63:0]   mac_answer, out_data;
   logic          out_valid, out_ready, out_last;

   conv5x5_controller #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .IMG_BASE(0)) dut (
      .clk(clk), .reset(reset), .start(start), .keep_w(keep_w), .busy(busy), .done(done),
      .img_rd(img_rd), .img_addr(img_addr), .img_data(img_data),
      .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data),
      .mac_data(mac_data), .mac_weight(mac_weight),
      .mac_data_count(mac_data_count), .mac_weight_count(mac_weight_count),
      .mac_data_en(mac_data_en), .mac_weight_en(mac_weight_en), .mac_update(mac_update),
      .mac_answer(mac_answer), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] img_mem [36];
   logic [31:0] w_mem   [26];
   logic [31:0] dbuf    [25];
   logic [31:0] wbuf    [26];

   always @(posedge clk) begin
      if (img_rd) img_data <= (img_addr < AW'(36)) ? img_mem[img_addr[5:0]] : 32'hDEAD_BEEF;
      if (w_rd)   w_data   <= w_mem[w_addr];
   end

   // Processor model: an update-qualified data write shifts every row one column left first.
   always @(posedge clk) begin
      if (mac_weight_en) wbuf[mac_weight_count] <= mac_weight;
      if (mac_data_en) begin
         if (mac_update)
            for (int i = 0; i < 25; i++)
               if (i % 5 != 4) dbuf[i] <= dbuf[i+1];
         dbuf[mac_data_count] <= mac_data;
      end
   end

   always_comb begin
      longint acc;
      acc = longint'($signed(wbuf[25]));
      for (int i = 0; i < 25; i++)
         acc = acc + longint'($signed(dbuf[i])) * longint'($signed(wbuf[i]));
      mac_answer = (acc < 0) ? 64'd0 : 64'(acc);
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   typedef struct packed {
      int              img_mode;   // 0 = all ones, 1 = pixel value equals its address
      int              w_mode;     // 0 = all ones, 1 = only weight[12] = 1
      int              bias;
      logic            kw;
      int              stall_idx;  // result index held off for 10 cycles, -1 = none
      logic [3:0][63:0] exp_res;
      int              exp_first;
   } vec_t;

   function automatic vec_t mk(input int im, input int wm, input int b, input logic kw,
                               input int st, input longint e0, input longint e1,
                               input longint e2, input longint e3, input int ef);
      vec_t v;
      v.img_mode = im; v.w_mode = wm; v.bias = b; v.kw = kw; v.stall_idx = st;
      v.exp_res[0] = e0; v.exp_res[1] = e1; v.exp_res[2] = e2; v.exp_res[3] = e3;
      v.exp_first = ef;
      return v;
   endfunction

   task automatic setup_mem(input int img_mode, input int w_mode, input int bias);
      for (int i = 0; i < 36; i++) img_mem[i] = (img_mode == 0) ? 32'd1 : 32'(i);
      for (int i = 0; i < 25; i++)
         w_mem[i] = (w_mode == 0) ? 32'd1 : ((i == 12) ? 32'd1 : 32'd0);
      w_mem[25] = 32'(bias);
   endtask

   longint res      [8];
   int     res_cyc  [8];
   logic   res_last [8];
   int     nres, wrd_cnt, overlap, stall_bad, done_rel, stall_seen;
   logic   busy_at_done;

   task automatic run_pass(input logic kw, input int stall_idx);
      int     s, stall_left;
      longint held;
      bit     got_done, first_stall;
      nres = 0; wrd_cnt = 0; overlap = 0; stall_bad = 0; done_rel = -1; stall_seen = 0;
      busy_at_done = 1'b1; stall_left = 10; first_stall = 1; got_done = 0; held = 0;
      @(posedge clk); #1;
      start = 1'b1; keep_w = kw; s = cyc;
      @(posedge clk); #1;
      start = 1'b0; keep_w = 1'b0;
      for (int k = 0; k < 2000 && !got_done; k++) begin
         @(negedge clk);
         if (w_rd) wrd_cnt++;
         if ((img_rd && w_rd) || (mac_data_en && mac_weight_en)) overlap++;
         if (done) begin
            got_done = 1; done_rel = cyc - s; busy_at_done = busy;
         end
         if (out_valid) begin
            if (nres == stall_idx && stall_left > 0) begin
               if (first_stall) begin
                  held = longint'(out_data); first_stall = 0;
               end else if (longint'(out_data) !== held) stall_bad++;
               if (img_rd) stall_bad++;
               out_ready = 1'b0;
               stall_left--;
               stall_seen++;
            end else begin
               out_ready = 1'b1;
               if (nres < 8) begin
                  res[nres] = longint'(out_data); res_last[nres] = out_last; res_cyc[nres] = cyc - s;
               end
               nres++;
            end
         end
      end
      chk("done_seen", longint'(got_done), 1);
      out_ready = 1'b1;
      @(negedge clk);
      chk("done_pulse_width", longint'(done), 0);
   endtask

   task automatic check_results(input string tag, input vec_t v);
      logic [3:0] lm;
      chk({tag, " result_count"}, nres, 4);
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("%s result%0d", tag, j), res[j], longint'(v.exp_res[j]));
         lm[j] = res_last[j];
      end
      chk({tag, " out_last_mask"}, longint'(lm), 8);
      chk({tag, " first_valid_cycle"}, res_cyc[0], v.exp_first);
      chk({tag, " done_after_last"}, done_rel, res_cyc[3] + 1);
      chk({tag, " busy_at_done"}, longint'(busy_at_done), 0);
      chk({tag, " w_rd_pulses"}, wrd_cnt, v.kw ? 0 : 26);
      chk({tag, " rd_or_en_overlap"}, overlap, 0);
   endtask

   function automatic int outs_nonzero();
      return ((|{busy, done, img_rd, img_addr, w_rd, w_addr, mac_data, mac_weight,
                 mac_data_count, mac_weight_count, mac_data_en, mac_weight_en, mac_update,
                 out_valid, out_data, out_last}) === 1'b0) ? 0 : 1;
   endfunction

   vec_t vecs [5];

   initial begin
      vecs[0] = mk(0, 0,    0, 1'b0, -1, 25, 25, 25, 25, 55);
      vecs[1] = mk(0, 0, -100, 1'b0, -1,  0,  0,  0,  0, 55);
      vecs[2] = mk(1, 1,    0, 1'b0, -1, 14, 15, 20, 21, 55);
      vecs[3] = mk(1, 0,    0, 1'b1, -1, 14, 15, 20, 21, 28);  // RAM weights changed, must not reload
      vecs[4] = mk(1, 1,    0, 1'b0,  1, 14, 15, 20, 21, 55);

      reset = 1'b1; start = 1'b0; keep_w = 1'b0; out_ready = 1'b1;
      setup_mem(0, 0, 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_outputs_zero", outs_nonzero(), 0);

      for (int i = 0; i < 5; i++) begin
         setup_mem(vecs[i].img_mode, vecs[i].w_mode, vecs[i].bias);
         run_pass(vecs[i].kw, vecs[i].stall_idx);
         check_results($sformatf("vec%0d", i), vecs[i]);
         if (vecs[i].stall_idx < 0) begin
            chk($sformatf("vec%0d same_row_gap", i), res_cyc[1] - res_cyc[0], 8);
            chk($sformatf("vec%0d new_row_gap", i), res_cyc[2] - res_cyc[1], 28);
            chk($sformatf("vec%0d second_row_gap", i), res_cyc[3] - res_cyc[2], 8);
         end else begin
            chk($sformatf("vec%0d stall_cycles", i), stall_seen, 10);
            chk($sformatf("vec%0d stall_stable_no_rd", i), stall_bad, 0);
         end
      end

      // Abort a pass in the middle of the full window load, then rerun cleanly.
      setup_mem(1, 1, 0);
      @(posedge clk); #1;
      start = 1'b1; keep_w = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (38) @(posedge clk);
      @(negedge clk);
      chk("midpass_in_load_win", longint'(img_rd && busy), 1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("midpass_reset_outputs_zero", outs_nonzero(), 0);
      run_pass(1'b0, -1);
      check_results("after_reset", vecs[2]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
